piso_shifter_ctrl: RTL and testbench

- Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, a bit counter and a frame-done pulse.
- Generalises the fixed 4-bit PISO in three ways: width, shift direction and bit-rate enable.
- Sits between a parallel word producer (FIFO or register file) and a serial line driver (UART/SPI-style TX path).
- Supports back-to-back frames with no idle bit.

---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_bit_counter.sv | 39 +++
 rtl/piso_shifter_ctrl.sv | 126 ++++++++++++
 tb/tb_piso_shifter_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO shifter.
// The PISO_PARITY_EN macro appends one even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Bits needed to count down from n-1 to 0; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with a zero flag. It tracks the bits left in a frame.
// Load takes priority over decrement, and the count saturates at zero.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/piso_shifter_ctrl.sv
// Parallel-in/serial-out shifter with a valid/ready load, a frame-done pulse and back-to-back frames.
// Defining PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shifter_ctrl
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int FRAME_BITS = WIDTH + PARITY_BITS;
    localparam int CNT_W      = cnt_width(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

    // The parity bit sits at the tail end, so it reaches the head after the data bits.
    function automatic logic [FRAME_BITS-1:0] load_word(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
        if (LSB_FIRST) begin
            return {^d, d};
        end else begin
            return {d, ^d};
        end
`else
        return d;
`endif
    endfunction

    function automatic logic head_bit(input logic [FRAME_BITS-1:0] sr);
        return LSB_FIRST ? sr[0] : sr[FRAME_BITS-1];
    endfunction

    function automatic logic [FRAME_BITS-1:0] shift_once(input logic [FRAME_BITS-1:0] sr);
        return LSB_FIRST ? (sr >> 1) : (sr << 1);
    endfunction

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic                  ser_out_q, ser_out_d;
    logic                  cnt_load, cnt_dec, cnt_zero;
    logic                  rdy_c, done_c;

    piso_bit_counter #(
        .WIDTH(FRAME_BITS)
    ) u_bit_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(LAST_IDX),
        .is_zero (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        rdy_c    = 1'b0;
        done_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                rdy_c = 1'b1;
                if (in_valid) begin
                    sr_d     = load_word(in_data);
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_zero) begin
                        // Last bit consumed: the same edge may load the next word.
                        done_c = 1'b1;
                        rdy_c  = 1'b1;
                        if (in_valid) begin
                            sr_d     = load_word(in_data);
                            cnt_load = 1'b1;
                        end else begin
                            sr_d    = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sr_d    = shift_once(sr_q);
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ser_out_d = (state_d == SHIFT) ? head_bit(sr_d) : IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            ser_out_q <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            ser_out_q <= ser_out_d;
        end
    end

    assign in_ready  = rdy_c & reset_n;
    assign done      = done_c;
    assign busy      = (state_q == SHIFT);
    assign ser_valid = busy;
    assign ser_out   = ser_out_q;

endmodule

// File: tb/tb_piso_shifter_ctrl.sv
// Bench for piso_shifter_ctrl: an MSB-first/idle-0 and an LSB-first/idle-1 instance share one stimulus.
// A bit-queue reference model predicts every output on every cycle.
module tb_piso_shifter_ctrl;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FB = WIDTH + 1;
`else
    localparam int FB = WIDTH;
`endif

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             shift_en;
    logic [1:0]       in_ready, ser_out, ser_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the bits still to be sent in the current frame, head first.
    bit mq0[$];
    bit mq1[$];
    bit model_acc;

    // Statistics for the directed frames, taken from instance 0 unless noted.
    logic [31:0] seq0, seq1;
    int vcnt, dcnt, rcnt, cyc, first_v, last_v;

    piso_shifter_ctrl #(.WIDTH(WIDTH), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out[0]),
        .ser_valid(ser_valid[0]), .busy(busy[0]), .done(done[0])
    );

    piso_shifter_ctrl #(.WIDTH(WIDTH), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out[1]),
        .ser_valid(ser_valid[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The frame as it appears on the line, first bit in the MSB position.
    function automatic logic [FB-1:0] frame_seq(input logic [WIDTH-1:0] w, input bit lsb);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < WIDTH; i++) d[i] = lsb ? w[WIDTH-1-i] : w[i];
`ifdef PISO_PARITY_EN
        return {d, ^w};
`else
        return d;
`endif
    endfunction

    task automatic cmp_one(input int k, input int sz, input bit head, input bit idle);
        bit act;
        act = (sz != 0);
        check_eq($sformatf("ser_out%0d", k),   ser_out[k],   act ? head : idle);
        check_eq($sformatf("ser_valid%0d", k), ser_valid[k], act);
        check_eq($sformatf("busy%0d", k),      busy[k],      act);
        check_eq($sformatf("in_ready%0d", k),  in_ready[k],
                 reset_n && (!act || (sz == 1 && shift_en)));
        check_eq($sformatf("done%0d", k),      done[k],      act && sz == 1 && shift_en);
    endtask

    task automatic compare();
        cmp_one(0, mq0.size(), (mq0.size() != 0) ? mq0[0] : 1'b0, 1'b0);
        cmp_one(1, mq1.size(), (mq1.size() != 0) ? mq1[0] : 1'b0, 1'b1);
        model_acc = reset_n && in_valid && (mq0.size() == 0 || (mq0.size() == 1 && shift_en));
        if (ser_valid[0]) begin
            if (vcnt == 0) first_v = cyc;
            last_v = cyc;
            vcnt++;
        end
        if (ser_valid[0] && shift_en) begin
            seq0 = {seq0[30:0], ser_out[0]};
            seq1 = {seq1[30:0], ser_out[1]};
        end
        if (done[0]) dcnt++;
        if (in_ready[0] && busy[0]) rcnt++;
    endtask

    task automatic advance();
        logic [FB-1:0] f0, f1;
        if (!reset_n) begin
            mq0.delete();
            mq1.delete();
        end else begin
            if (mq0.size() != 0 && shift_en) begin
                void'(mq0.pop_front());
                void'(mq1.pop_front());
            end
            if (model_acc) begin
                f0 = frame_seq(in_data, 1'b0);
                f1 = frame_seq(in_data, 1'b1);
                for (int i = FB - 1; i >= 0; i--) begin
                    mq0.push_back(f0[i]);
                    mq1.push_back(f1[i]);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        advance();
        #1;
        cyc++;
    endtask

    task automatic clear_stats();
        seq0 = '0; seq1 = '0;
        vcnt = 0; dcnt = 0; rcnt = 0; first_v = 0; last_v = 0;
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] w, input int period);
        clear_stats();
        in_valid = 1'b1;
        in_data  = w;
        shift_en = (period == 1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < FB * period; i++) begin
            shift_en = ((i % period) == period - 1);
            step();
        end
        shift_en = 1'b0;
        step();
        check_eq($sformatf("seq_msb_%0h", w), seq0, 32'(frame_seq(w, 1'b0)));
        check_eq($sformatf("seq_lsb_%0h", w), seq1, 32'(frame_seq(w, 1'b1)));
        check_eq($sformatf("valid_cycles_%0h", w), vcnt, FB * period);
        check_eq($sformatf("done_pulses_%0h", w), dcnt, 1);
    endtask

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        shift_en = 1'b0;
        cyc      = 0;
        model_acc = 1'b0;
        clear_stats();
        #2 reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        #1;
        check_eq("ready_after_reset", in_ready[0], 1'b1);
        step();

        // Single frames: spec words, strobe every cycle, then every third cycle.
        run_frame(8'hA5, 1);
        run_frame(8'h03, 1);
        run_frame(8'h81, 1);
        run_frame(8'h07, 1);
        run_frame(8'h3C, 3);

        // Back-to-back frames with in_valid held high.
        clear_stats();
        in_valid = 1'b1;
        in_data  = 8'hF0;
        shift_en = 1'b1;
        step();
        in_data = 8'h0F;
        for (int i = 0; i < FB; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < FB; i++) step();
        shift_en = 1'b0;
        step();
        check_eq("b2b_seq_msb", seq0, 32'({frame_seq(8'hF0, 1'b0), frame_seq(8'h0F, 1'b0)}));
        check_eq("b2b_seq_lsb", seq1, 32'({frame_seq(8'hF0, 1'b1), frame_seq(8'h0F, 1'b1)}));
        check_eq("b2b_valid_cycles", vcnt, 2 * FB);
        check_eq("b2b_contiguous", last_v - first_v + 1, 2 * FB);
        check_eq("b2b_done_pulses", dcnt, 2);
        check_eq("b2b_ready_in_frame", rcnt, 2);

        // Asynchronous reset after four bits of 8'hFF.
        clear_stats();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        shift_en = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        mq0.delete();
        mq1.delete();
        #1;
        check_eq("abort_ser_out0", ser_out[0], 1'b0);
        check_eq("abort_ser_out1", ser_out[1], 1'b1);
        check_eq("abort_busy0", busy[0], 1'b0);
        check_eq("abort_busy1", busy[1], 1'b0);
        check_eq("abort_done0", done[0], 1'b0);
        repeat (2) step();
        check_eq("abort_no_done", dcnt, 0);
        reset_n = 1'b1;
        step();
        run_frame(8'h01, 1);

        // Random traffic; the producer holds its word until it is accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!(in_valid && !model_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = WIDTH'($urandom);
            end
            shift_en = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                mq0.delete();
                mq1.delete();
                step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
